// File: rtl/npg_pulse_monitor.sv
// npg_pulse_monitor: receive-side checker for the stimulator pin interface.
// Build option: define MON_SHORT_CHECK_EN to flag up/down rail overlap as an error.
module npg_pulse_monitor #(
    parameter int SW_W        = 3,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int OFF_DETECT  = 1000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [SW_W-1:0]  up_switches,
    input  logic [SW_W-1:0]  down_switches,
    input  logic [5:0]       dac,
    input  logic             pulse_active,
    input  logic             clear,
    output logic             pulse_valid,
    input  logic             pulse_ready,
    output logic [CNT_W-1:0] phase1_len,
    output logic [CNT_W-1:0] phase2_len,
    output logic [5:0]       dac_peak,
    output logic [CNT_W-1:0] period,
    output logic             burst_done,
    output logic [CNT_W-1:0] burst_pulses,
    output logic [CNT_W-1:0] burst_on_len,
    output logic             overrun,
    output logic             error
);

    localparam int PAT_W = 2 * SW_W;
    localparam int IN_W  = PAT_W + 7;
    localparam int NS    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(OFF_DETECT);

    typedef enum logic [2:0] {
        IDLE,
        PH1,
        PH2,
        DONE,
        GAP
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic [NS-1:0][IN_W-1:0] sync_q;
    logic [IN_W-1:0]         raw;
    logic [IN_W-1:0]         s;

    logic                    pa_s;
    logic [5:0]              dac_s;
    logic [PAT_W-1:0]        pat_s;

    assign raw   = {pulse_active, dac, up_switches, down_switches};
    assign s     = sync_q[NS-1];
    assign pa_s  = s[IN_W-1];
    assign dac_s = s[IN_W-2 -: 6];
    assign pat_s = s[PAT_W-1:0];

    state_t           state_q, state_d;
    logic             pa_prev_q;
    logic [PAT_W-1:0] pat_prev_q;
    logic [PAT_W-1:0] pat1_q, pat1_d;
    logic [CNT_W-1:0] p1_q, p1_d;
    logic [CNT_W-1:0] p2_q, p2_d;
    logic [5:0]       peak_q, peak_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic             ref_vld_q, ref_vld_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] on_cnt_q, on_cnt_d;
    logic [CNT_W-1:0] on_last_q, on_last_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic             dac_idle_q;

    logic             vld_q, vld_d;
    logic [CNT_W-1:0] r_p1_q, r_p1_d;
    logic [CNT_W-1:0] r_p2_q, r_p2_d;
    logic [5:0]       r_pk_q, r_pk_d;
    logic [CNT_W-1:0] r_per_q, r_per_d;
    logic             bdone_q, bdone_d;
    logic [CNT_W-1:0] bpulses_q, bpulses_d;
    logic [CNT_W-1:0] bon_q, bon_d;
    logic             ovr_q, ovr_d;
    logic             err_q, err_d;

    logic             rise;
    logic             start;
    logic             ovr_set;
    logic             fsm_err;
    logic             idle_now;
    logic             short_err;

    assign rise     = pa_s & ~pa_prev_q;
    assign idle_now = ~pa_s & (dac_s != 6'd0);

`ifdef MON_SHORT_CHECK_EN
    assign short_err = |(pat_s[PAT_W-1:SW_W] & pat_s[SW_W-1:0]);
`else
    assign short_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pat1_d    = pat1_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        peak_d    = peak_q;
        per_d     = per_q;
        per_cnt_d = sat_inc(per_cnt_q);
        ref_vld_d = ref_vld_q;
        gap_d     = gap_q;
        on_cnt_d  = sat_inc(on_cnt_q);
        on_last_d = on_last_q;
        bcnt_d    = bcnt_q;
        vld_d     = vld_q;
        r_p1_d    = r_p1_q;
        r_p2_d    = r_p2_q;
        r_pk_d    = r_pk_q;
        r_per_d   = r_per_q;
        bdone_d   = 1'b0;
        bpulses_d = bpulses_q;
        bon_d     = bon_q;
        ovr_set   = 1'b0;
        fsm_err   = 1'b0;
        start     = 1'b0;

        if (vld_q && pulse_ready) begin
            vld_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                start = rise;
            end
            PH1: begin
                if (!pa_s) begin
                    state_d   = DONE;
                    p2_d      = '0;
                    fsm_err   = 1'b1;
                    on_last_d = on_cnt_q;
                end else begin
                    if (dac_s > peak_q) begin
                        peak_d = dac_s;
                    end
                    if (pat_s == pat1_q) begin
                        p1_d = sat_inc(p1_q);
                    end else begin
                        state_d = PH2;
                        p2_d    = CNT_ONE;
                    end
                end
            end
            PH2: begin
                if (!pa_s) begin
                    state_d   = DONE;
                    on_last_d = on_cnt_q;
                end else begin
                    if (dac_s > peak_q) begin
                        peak_d = dac_s;
                    end
                    p2_d = sat_inc(p2_q);
                    if (pat_s != pat_prev_q && pat_s != '0) begin
                        fsm_err = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!vld_q || pulse_ready) begin
                    vld_d   = 1'b1;
                    r_p1_d  = p1_q;
                    r_p2_d  = p2_q;
                    r_pk_d  = peak_q;
                    r_per_d = per_q;
                end else begin
                    ovr_set = 1'b1;
                end
                bcnt_d  = sat_inc(bcnt_q);
                gap_d   = '0;
                state_d = GAP;
                start   = rise;
            end
            GAP: begin
                gap_d = sat_inc(gap_q);
                start = rise;
                if (!rise && gap_d >= OFF_LIM) begin
                    state_d   = IDLE;
                    bdone_d   = 1'b1;
                    bpulses_d = bcnt_q;
                    bon_d     = on_last_q;
                    bcnt_d    = '0;
                    ref_vld_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A rise after DONE/GAP continues the burst; only IDLE restarts ON time.
        if (start) begin
            state_d   = PH1;
            pat1_d    = pat_s;
            p1_d      = CNT_ONE;
            p2_d      = '0;
            peak_d    = dac_s;
            per_d     = ref_vld_q ? per_cnt_q : '0;
            ref_vld_d = 1'b1;
            if (state_q == IDLE) begin
                on_cnt_d = CNT_ONE;
            end
        end

        if (rise) begin
            per_cnt_d = CNT_ONE;
        end

        if (clear) begin
            bpulses_d = '0;
            bon_d     = '0;
        end
    end

    assign ovr_d = clear ? 1'b0 : (ovr_q | ovr_set);
    assign err_d = clear ? 1'b0
                 : (err_q | fsm_err | (idle_now & dac_idle_q) | short_err);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q     <= '0;
            pa_prev_q  <= 1'b0;
            pat_prev_q <= '0;
            state_q    <= IDLE;
            pat1_q     <= '0;
            p1_q       <= '0;
            p2_q       <= '0;
            peak_q     <= '0;
            per_q      <= '0;
            per_cnt_q  <= '0;
            ref_vld_q  <= 1'b0;
            gap_q      <= '0;
            on_cnt_q   <= '0;
            on_last_q  <= '0;
            bcnt_q     <= '0;
            dac_idle_q <= 1'b0;
            vld_q      <= 1'b0;
            r_p1_q     <= '0;
            r_p2_q     <= '0;
            r_pk_q     <= '0;
            r_per_q    <= '0;
            bdone_q    <= 1'b0;
            bpulses_q  <= '0;
            bon_q      <= '0;
            ovr_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[NS-2:0], raw};
            pa_prev_q  <= pa_s;
            pat_prev_q <= pat_s;
            state_q    <= state_d;
            pat1_q     <= pat1_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            peak_q     <= peak_d;
            per_q      <= per_d;
            per_cnt_q  <= per_cnt_d;
            ref_vld_q  <= ref_vld_d;
            gap_q      <= gap_d;
            on_cnt_q   <= on_cnt_d;
            on_last_q  <= on_last_d;
            bcnt_q     <= bcnt_d;
            dac_idle_q <= idle_now;
            vld_q      <= vld_d;
            r_p1_q     <= r_p1_d;
            r_p2_q     <= r_p2_d;
            r_pk_q     <= r_pk_d;
            r_per_q    <= r_per_d;
            bdone_q    <= bdone_d;
            bpulses_q  <= bpulses_d;
            bon_q      <= bon_d;
            ovr_q      <= ovr_d;
            err_q      <= err_d;
        end
    end

    assign pulse_valid  = vld_q;
    assign phase1_len   = r_p1_q;
    assign phase2_len   = r_p2_q;
    assign dac_peak     = r_pk_q;
    assign period       = r_per_q;
    assign burst_done   = bdone_q;
    assign burst_pulses = bpulses_q;
    assign burst_on_len = bon_q;
    assign overrun      = ovr_q;
    assign error        = err_q;

endmodule

// File: tb/tb_npg_pulse_monitor.sv
// tb_npg_pulse_monitor: directed table-driven bench for npg_pulse_monitor.
module tb_npg_pulse_monitor;

    localparam int SW_W  = 3;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [SW_W-1:0]  up_switches = '0;
    logic [SW_W-1:0]  down_switches = '0;
    logic [5:0]       dac = '0;
    logic             pulse_active = 1'b0;
    logic             clear = 1'b0;
    logic             pulse_valid;
    logic             pulse_ready = 1'b1;
    logic [CNT_W-1:0] phase1_len;
    logic [CNT_W-1:0] phase2_len;
    logic [5:0]       dac_peak;
    logic [CNT_W-1:0] period;
    logic             burst_done;
    logic [CNT_W-1:0] burst_pulses;
    logic [CNT_W-1:0] burst_on_len;
    logic             overrun;
    logic             error;

    npg_pulse_monitor #(
        .SW_W(SW_W),
        .CNT_W(CNT_W),
        .SYNC_STAGES(2),
        .OFF_DETECT(1000)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .up_switches(up_switches),
        .down_switches(down_switches),
        .dac(dac),
        .pulse_active(pulse_active),
        .clear(clear),
        .pulse_valid(pulse_valid),
        .pulse_ready(pulse_ready),
        .phase1_len(phase1_len),
        .phase2_len(phase2_len),
        .dac_peak(dac_peak),
        .period(period),
        .burst_done(burst_done),
        .burst_pulses(burst_pulses),
        .burst_on_len(burst_on_len),
        .overrun(overrun),
        .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CNT_W-1:0] p1;
        logic [CNT_W-1:0] p2;
        logic [5:0]       pk;
        logic [CNT_W-1:0] per;
    } res_t;

    typedef struct {
        int         gap;
        logic [2:0] u1, d1;
        int         n1;
        logic [5:0] a1;
        logic [2:0] u2, d2;
        int         n2;
        logic [5:0] a2;
        int         e_p1, e_p2, e_pk, e_per, e_err;
        int         burst, e_bp, e_bon;
    } vec_t;

    res_t             resq[$];
    int               bd_cnt = 0;
    logic [CNT_W-1:0] bd_pulses = '0;
    logic [CNT_W-1:0] bd_on = '0;
    int               checks = 0;
    int               errors = 0;

    always @(negedge clk) begin
        if (resetn && pulse_valid && pulse_ready)
            resq.push_back({phase1_len, phase2_len, dac_peak, period});
        if (burst_done) begin
            bd_cnt    <= bd_cnt + 1;
            bd_pulses <= burst_pulses;
            bd_on     <= burst_on_len;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic pa, input logic [2:0] u,
                         input logic [2:0] d, input logic [5:0] dv,
                         input int n);
        pulse_active  = pa;
        up_switches   = u;
        down_switches = d;
        dac           = dv;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] u1, input logic [2:0] d1,
                         input int n1, input logic [5:0] a1,
                         input logic [2:0] u2, input logic [2:0] d2,
                         input int n2, input logic [5:0] a2);
        drive(1'b1, u1, d1, a1, n1);
        drive(1'b1, u2, d2, a2, n2);
        drive(1'b0, 3'b000, 3'b000, 6'd0, 10);
    endtask

    task automatic wait_burst(input int prev);
        int k;
        k = 0;
        while (bd_cnt == prev && k < 1500) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("burst_done seen", bd_cnt, prev + 1);
    endtask

    task automatic pop_check(input string tag, input int e_p1,
                             input int e_p2, input int e_pk,
                             input int e_per);
        res_t r;
        chk({tag, " result count"}, resq.size(), 1);
        if (resq.size() > 0) begin
            r = resq.pop_front();
            chk({tag, " phase1_len"}, r.p1, e_p1);
            chk({tag, " phase2_len"}, r.p2, e_p2);
            chk({tag, " dac_peak"}, r.pk, e_pk);
            chk({tag, " period"}, r.per, e_per);
        end
    endtask

    vec_t tbl[4];
    int   nb;
    int   exp_short;

    initial begin
        // Rise-to-rise spacing is n1 + n2 + 10 (tail) + next gap.
        tbl[0] = '{5,   3'b100, 3'b010, 4, 6'd50, 3'b010, 3'b100, 4, 6'd50,
                   4, 4, 50, 0, 0, 0, 0, 0};
        tbl[1] = '{382, 3'b100, 3'b010, 4, 6'd50, 3'b010, 3'b100, 4, 6'd50,
                   4, 4, 50, 400, 0, 1, 2, 408};
        tbl[2] = '{20,  3'b001, 3'b000, 3, 6'd10, 3'b000, 3'b001, 5, 6'd33,
                   3, 5, 33, 0, 0, 0, 0, 0};
        tbl[3] = '{40,  3'b100, 3'b010, 6, 6'd25, 3'b000, 3'b000, 0, 6'd0,
                   6, 0, 25, 58, 1, 1, 2, 64};

        #2;
        chk("reset pulse_valid", pulse_valid, 0);
        chk("reset phase1_len", phase1_len, 0);
        chk("reset phase2_len", phase2_len, 0);
        chk("reset dac_peak", dac_peak, 0);
        chk("reset period", period, 0);
        chk("reset burst_done", burst_done, 0);
        chk("reset burst_pulses", burst_pulses, 0);
        chk("reset burst_on_len", burst_on_len, 0);
        chk("reset overrun", overrun, 0);
        chk("reset error", error, 0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 3'b000, 3'b000, 6'd0, tbl[i].gap);
            pulse(tbl[i].u1, tbl[i].d1, tbl[i].n1, tbl[i].a1,
                  tbl[i].u2, tbl[i].d2, tbl[i].n2, tbl[i].a2);
            pop_check($sformatf("vec%0d", i), tbl[i].e_p1, tbl[i].e_p2,
                      tbl[i].e_pk, tbl[i].e_per);
            chk($sformatf("vec%0d error", i), error, tbl[i].e_err);
            if (tbl[i].burst != 0) begin
                nb = bd_cnt;
                wait_burst(nb);
                chk($sformatf("vec%0d burst_pulses", i), bd_pulses, tbl[i].e_bp);
                chk($sformatf("vec%0d burst_on_len", i), bd_on, tbl[i].e_bon);
            end
        end

        clear = 1'b1;
        drive(1'b0, 3'b000, 3'b000, 6'd0, 1);
        clear = 1'b0;
        chk("clear error", error, 0);
        chk("clear burst_pulses", burst_pulses, 0);

        pulse_ready = 1'b0;
        drive(1'b0, 3'b000, 3'b000, 6'd0, 5);
        pulse(3'b100, 3'b010, 4, 6'd50, 3'b010, 3'b100, 4, 6'd50);
        pulse(3'b001, 3'b000, 3, 6'd7, 3'b000, 3'b001, 3, 6'd7);
        chk("ovr pulse_valid", pulse_valid, 1);
        chk("ovr held phase1_len", phase1_len, 4);
        chk("ovr held phase2_len", phase2_len, 4);
        chk("ovr held dac_peak", dac_peak, 50);
        chk("ovr held period", period, 0);
        chk("ovr overrun", overrun, 1);
        clear = 1'b1;
        drive(1'b0, 3'b000, 3'b000, 6'd0, 1);
        clear = 1'b0;
        chk("ovr cleared", overrun, 0);
        chk("ovr valid kept", pulse_valid, 1);
        pulse_ready = 1'b1;
        drive(1'b0, 3'b000, 3'b000, 6'd0, 2);
        pop_check("ovr", 4, 4, 50, 0);
        chk("ovr valid dropped", pulse_valid, 0);

        drive(1'b0, 3'b000, 3'b000, 6'd20, 3);
        drive(1'b0, 3'b000, 3'b000, 6'd0, 6);
        chk("dac idle error", error, 1);
        clear = 1'b1;
        drive(1'b0, 3'b000, 3'b000, 6'd0, 1);
        clear = 1'b0;
        chk("dac idle cleared", error, 0);

`ifdef MON_SHORT_CHECK_EN
        exp_short = 1;
`else
        exp_short = 0;
`endif
        drive(1'b0, 3'b001, 3'b001, 6'd0, 3);
        drive(1'b0, 3'b000, 3'b000, 6'd0, 6);
        chk("short error", error, exp_short);
        clear = 1'b1;
        drive(1'b0, 3'b000, 3'b000, 6'd0, 1);
        clear = 1'b0;

        pulse_ready = 1'b0;
        pulse(3'b100, 3'b010, 4, 6'd50, 3'b010, 3'b100, 4, 6'd50);
        chk("pre-reset valid", pulse_valid, 1);
        drive(1'b1, 3'b100, 3'b010, 6'd30, 4);
        drive(1'b1, 3'b010, 3'b100, 6'd30, 5);
        resetn = 1'b0;
        #1;
        chk("midreset pulse_valid", pulse_valid, 0);
        chk("midreset phase1_len", phase1_len, 0);
        chk("midreset phase2_len", phase2_len, 0);
        chk("midreset dac_peak", dac_peak, 0);
        chk("midreset period", period, 0);
        chk("midreset burst_on_len", burst_on_len, 0);
        drive(1'b0, 3'b000, 3'b000, 6'd0, 3);
        resetn = 1'b1;
        pulse_ready = 1'b1;
        drive(1'b0, 3'b000, 3'b000, 6'd0, 5);
        pulse(3'b010, 3'b001, 5, 6'd9, 3'b001, 3'b010, 3, 6'd9);
        pop_check("postreset", 5, 3, 9, 0);
        chk("postreset error", error, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
